// File: rtl/placar_seq_pkg.sv
// Shared constants, FSM state type and BCD-to-segment mapping for the
// score display driver.
package placar_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_NINE  = 7'h10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Active-low a..g code (bit0 = a); non-decimal inputs show nothing.
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/placar_seq_if.sv
// Request/result bundle between score logic (master) and the display driver (slave).
interface placar_seq_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [BIN_W-1:0]      value;
  logic                  blank_en;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [7*DIGITS-1:0]   hex;

  modport master (
    output start, value, blank_en,
    input  busy, done, overflow, hex
  );

  modport slave (
    input  start, value, blank_en,
    output busy, done, overflow, hex
  );
endinterface

// File: rtl/placar_seq_seg7_decoder.sv
// Combinational single-digit BCD to active-low 7-segment decoder.
module seg7_decoder
  import placar_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_code(bcd_i);

endmodule

// File: rtl/placar_seq.sv
// Sequential binary-to-BCD score display driver: shift-add-3 conversion over
// BIN_W cycles, then a registered update of all segment codes.
module placar_seq
  import placar_pkg::*;
#(
  parameter int BIN_W    = 20,
  parameter int DIGITS   = 6,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  placar_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int HEX_W = 7 * DIGITS;

  state_t               state_q, state_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [HEX_W-1:0]     hex_q, hex_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;
  logic                 blank_q;

  logic [BCD_W-1:0]     bcd_adj;
  logic [HEX_W-1:0]     hex_fin;
  logic [6:0]           seg_w [DIGITS];
  logic                 accept;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];

      seg7_decoder u_dec (
        .bcd_i (bcd_q[4*gi +: 4]),
        .seg_o (seg_w[gi])
      );

      // A digit is blanked only when it and every digit above it are zero.
      if (gi == 0) begin : g_lsd
        assign hex_fin[6:0] = ovf_q ? SEG_NINE : seg_w[0];
      end else begin : g_upper
        logic nz_from;
        assign nz_from = |bcd_q[BCD_W-1:4*gi];
        assign hex_fin[7*gi +: 7] = ovf_q                ? SEG_NINE  :
                                    (blank_q && !nz_from) ? SEG_BLANK :
                                                            seg_w[gi];
      end
    end
  endgenerate

  // FINISH is not busy, so a start there chains straight into the next conversion.
  assign accept = bus.start && (state_q != SHIFT);

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    hex_d      = hex_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: ;
      SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_q | bcd_adj[BCD_W-1];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        hex_d      = hex_fin;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      bin_d   = bus.value;
      bcd_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = CNT_W'(BIN_W);
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      hex_q      <= {DIGITS{SEG_BLANK}};
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      blank_q    <= BLANK_LZ;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      hex_q      <= hex_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      blank_q    <= bus.blank_en;
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.hex      = hex_q;

endmodule

// File: tb/tb_placar_seq.sv
// Directed bench for placar_seq: 6-digit and 7-digit instances sharing clock and reset.
module tb_placar_seq;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   n;
  int   bc;
  int   n7;

  localparam logic [41:0] H_123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
  localparam logic [41:0] H_ZERO_B = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [41:0] H_ZERO_N = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [41:0] H_NINES  = {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
  localparam logic [41:0] H_42     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24};
  localparam logic [41:0] H_7      = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
  localparam logic [41:0] H_9      = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10};
  localparam logic [41:0] H_BLANK  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [48:0] H7_MAX   = {7'h79, 7'h40, 7'h19, 7'h00, 7'h12, 7'h78, 7'h12};

  placar_seq_if #(.BIN_W(20), .DIGITS(6)) bus6 ();
  placar_seq_if #(.BIN_W(20), .DIGITS(7)) bus7 ();

  placar_seq #(.BIN_W(20), .DIGITS(6), .BLANK_LZ(1'b1)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  placar_seq #(.BIN_W(20), .DIGITS(7), .BLANK_LZ(1'b1)) dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse6(input logic [19:0] v, input logic be);
    bus6.value    = v;
    bus6.blank_en = be;
    bus6.start    = 1'b1;
    @(negedge clk);
    bus6.start    = 1'b0;
  endtask

  // Counts negedges until done (or limit); bco counts cycles with busy=1, entry included.
  task automatic wait6(input int limit, output int no, output int bco);
    no  = 0;
    bco = (bus6.busy === 1'b1) ? 1 : 0;
    do begin
      @(negedge clk);
      no++;
      if (bus6.busy === 1'b1) bco++;
    end while (bus6.done !== 1'b1 && no < limit);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus6.start = 1'b0; bus6.value = '0; bus6.blank_en = 1'b1;
    bus7.start = 1'b0; bus7.value = '0; bus7.blank_en = 1'b1;
    #12;
    check("rst_busy", 64'(bus6.busy), 64'd0);
    check("rst_done", 64'(bus6.done), 64'd0);
    check("rst_ovf",  64'(bus6.overflow), 64'd0);
    check("rst_hex",  64'(bus6.hex), 64'(H_BLANK));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic conversion, latency and busy length
    pulse6(20'd123456, 1'b1);
    wait6(60, n, bc);
    $display("conv 123456: latency=%0d busy_cycles=%0d hex=%h", n, bc, bus6.hex);
    check("t1_latency", 64'(n), 64'd21);
    check("t1_busy_cycles", 64'(bc), 64'd20);
    check("t1_hex", 64'(bus6.hex), 64'(H_123456));
    check("t1_ovf", 64'(bus6.overflow), 64'd0);
    check("t1_busy_at_done", 64'(bus6.busy), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'(bus6.done), 64'd0);
    check("t1_hex_hold", 64'(bus6.hex), 64'(H_123456));

    // 2: zero with and without blanking
    pulse6(20'd0, 1'b1);
    wait6(60, n, bc);
    $display("conv 0 blank: latency=%0d hex=%h", n, bus6.hex);
    check("t2_hex_blank", 64'(bus6.hex), 64'(H_ZERO_B));
    pulse6(20'd0, 1'b0);
    wait6(60, n, bc);
    $display("conv 0 noblank: latency=%0d hex=%h", n, bus6.hex);
    check("t2_hex_noblank", 64'(bus6.hex), 64'(H_ZERO_N));

    // 3: overflow saturation, then recovery
    pulse6(20'd1000000, 1'b1);
    wait6(60, n, bc);
    $display("conv 1000000: ovf=%0b hex=%h", bus6.overflow, bus6.hex);
    check("t3_ovf_set", 64'(bus6.overflow), 64'd1);
    check("t3_hex_nines", 64'(bus6.hex), 64'(H_NINES));
    repeat (3) @(negedge clk);
    check("t3_ovf_hold", 64'(bus6.overflow), 64'd1);
    pulse6(20'd42, 1'b1);
    wait6(60, n, bc);
    $display("conv 42: ovf=%0b hex=%h", bus6.overflow, bus6.hex);
    check("t3_ovf_clear", 64'(bus6.overflow), 64'd0);
    check("t3_hex_42", 64'(bus6.hex), 64'(H_42));

    // 4a: starts while busy are ignored
    pulse6(20'd123456, 1'b1);
    repeat (5) @(negedge clk);
    bus6.value = 20'd7;
    bus6.start = 1'b1;
    @(negedge clk);
    bus6.start = 1'b0;
    repeat (3) @(negedge clk);
    bus6.start = 1'b1;
    @(negedge clk);
    bus6.start = 1'b0;
    wait6(60, n, bc);
    $display("conv busy-ignore: remaining=%0d hex=%h", n, bus6.hex);
    check("t4_ignore_latency", 64'(n), 64'd11);
    check("t4_ignore_hex", 64'(bus6.hex), 64'(H_123456));
    wait6(40, n, bc);
    check("t4_single_done", 64'(bus6.done), 64'd0);

    // 4b: start held high converts back to back
    bus6.value = 20'd7;
    bus6.start = 1'b1;
    @(negedge clk);
    wait6(60, n, bc);
    $display("held #1: latency=%0d hex=%h", n, bus6.hex);
    check("t4_held1_latency", 64'(n), 64'd21);
    check("t4_held1_hex", 64'(bus6.hex), 64'(H_7));
    bus6.value = 20'd9;
    wait6(60, n, bc);
    $display("held #2: period=%0d hex=%h", n, bus6.hex);
    check("t4_held2_period", 64'(n), 64'd21);
    check("t4_held2_hex", 64'(bus6.hex), 64'(H_7));
    wait6(60, n, bc);
    $display("held #3: period=%0d hex=%h", n, bus6.hex);
    check("t4_held3_period", 64'(n), 64'd21);
    check("t4_held3_hex", 64'(bus6.hex), 64'(H_9));
    bus6.start = 1'b0;
    wait6(60, n, bc);
    $display("held #4: period=%0d hex=%h", n, bus6.hex);
    check("t4_held4_period", 64'(n), 64'd21);
    check("t4_held4_hex", 64'(bus6.hex), 64'(H_9));
    wait6(40, n, bc);
    check("t4_held_stop", 64'(bus6.done), 64'd0);

    // 5: asynchronous reset mid-conversion
    pulse6(20'd123456, 1'b1);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: busy=%0b done=%0b hex=%h", bus6.busy, bus6.done, bus6.hex);
    check("t5_rst_busy", 64'(bus6.busy), 64'd0);
    check("t5_rst_done", 64'(bus6.done), 64'd0);
    check("t5_rst_hex", 64'(bus6.hex), 64'(H_BLANK));
    @(negedge clk);
    rst_n = 1'b1;
    wait6(40, n, bc);
    check("t5_no_done_after", 64'(bus6.done), 64'd0);
    check("t5_hex_after", 64'(bus6.hex), 64'(H_BLANK));

    // 6: seven-digit instance at full-scale input
    bus7.value = 20'd1048575;
    bus7.blank_en = 1'b1;
    bus7.start = 1'b1;
    @(negedge clk);
    bus7.start = 1'b0;
    n7 = 0;
    do begin
      @(negedge clk);
      n7++;
    end while (bus7.done !== 1'b1 && n7 < 60);
    $display("conv7 1048575: latency=%0d ovf=%0b hex=%h", n7, bus7.overflow, bus7.hex);
    check("t6_latency", 64'(n7), 64'd21);
    check("t6_hex", 64'(bus7.hex), 64'(H7_MAX));
    check("t6_ovf", 64'(bus7.overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
